// File: rtl/spi_flash_ctrl.sv
// Byte-level SPI master (mode 0, MSB first) for the configuration flash,
// mapped as a two-register device on the registered j1 IO bus.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no transfer; sck low, mosi holds last bit sent
// LOW   | sck low for CLKDIV cycles; mosi carries the current bit
// HIGH  | sck high for CLKDIV cycles; miso was sampled on entry
module spi_flash_ctrl #(
  parameter int CLKDIV = 2
) (
  input  logic        clk,
  input  logic        resetq,
  input  logic        wr,
  input  logic        rd,
  input  logic        addr,
  input  logic [15:0] wd,
  output logic [15:0] rdata,
  output logic        sck,
  output logic        mosi,
  input  logic        miso,
  output logic        cs_n
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOW,
    ST_HIGH
  } state_t;

  // Divider reload value; the divider counts down to zero once per phase.
  localparam logic [7:0] DIV_LOAD = 8'(CLKDIV - 1);

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  div_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  tx_sh;
  logic [7:0]  rx_sh;
  logic [7:0]  rx;
  logic        rx_valid;
  logic        overrun;
  logic        busy;
  logic        start;
  logic        rise;
  logic        fall;
  logic        done;
  logic        data_wr;
  logic        data_rd;
  logic        ctrl_wr;
  logic        unused_wd;

  assign data_wr   = wr & ~addr;
  assign data_rd   = rd & ~addr;
  assign ctrl_wr   = wr & addr;
  assign busy      = (state != ST_IDLE);
  assign mosi      = tx_sh[7];
  assign unused_wd = &{1'b0, wd[15:8]};

  // Next-state decode and phase-transition strobes for the datapath.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    rise      = 1'b0;
    fall      = 1'b0;
    done      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (data_wr) begin
          state_nxt = ST_LOW;
          start     = 1'b1;
        end
      end
      ST_LOW: begin
        if (div_cnt == 8'd0) begin
          state_nxt = ST_HIGH;
          rise      = 1'b1;
        end
      end
      ST_HIGH: begin
        if (div_cnt == 8'd0) begin
          if (bit_cnt == 3'd0) begin
            state_nxt = ST_IDLE;
            done      = 1'b1;
          end else begin
            state_nxt = ST_LOW;
            fall      = 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Shift registers, phase divider, bit counter and sck.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      div_cnt <= 8'd0;
      bit_cnt <= 3'd0;
      tx_sh   <= 8'h00;
      rx_sh   <= 8'h00;
      rx      <= 8'h00;
      sck     <= 1'b0;
    end else if (start) begin
      div_cnt <= DIV_LOAD;
      bit_cnt <= 3'd7;
      tx_sh   <= wd[7:0];
    end else if (rise) begin
      div_cnt <= DIV_LOAD;
      sck     <= 1'b1;
      rx_sh   <= {rx_sh[6:0], miso};
    end else if (fall) begin
      div_cnt <= DIV_LOAD;
      sck     <= 1'b0;
      tx_sh   <= {tx_sh[6:0], 1'b0};
      bit_cnt <= bit_cnt - 3'd1;
    end else if (done) begin
      sck     <= 1'b0;
      rx      <= rx_sh;
    end else if (busy) begin
      div_cnt <= div_cnt - 8'd1;
    end
  end

  // Status flags: completion set wins over a coincident DATA read clear.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (done)         rx_valid <= 1'b1;
      else if (data_rd) rx_valid <= 1'b0;
      if (data_wr && busy)        overrun <= 1'b1;
      else if (ctrl_wr && wd[1])  overrun <= 1'b0;
    end
  end

  // Chip select only changes between transfers so a byte is never cut short.
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq)               cs_n <= 1'b1;
    else if (ctrl_wr && !busy) cs_n <= ~wd[0];
  end

  // Register read mux.
  always_comb begin
    rdata = 16'h0000;
    if (addr) rdata = {12'h000, overrun, rx_valid, ~cs_n, busy};
    else      rdata = {8'h00, rx};
  end

endmodule

// File: tb/tb_spi_flash_ctrl.sv
// Directed + randomized bench for spi_flash_ctrl. A CLKDIV=2 instance runs
// the main sequence; a CLKDIV=1 instance covers reset mid-transfer.
module tb_spi_flash_ctrl;

  localparam int D = 2;

  logic        clk = 1'b0;
  logic        resetq, wr, rd, addr;
  logic [15:0] wd, rdata;
  logic        sck, mosi, miso, cs_n;
  logic        lb, miso_drv;

  logic        resetq1, wr1, rd1, addr1;
  logic [15:0] wd1, rdata1;
  logic        sck1, mosi1, miso1, cs_n1;

  int          tests = 0;
  int          fails = 0;
  int          n_busy, rises, highs;
  logic [7:0]  cap;
  logic [15:0] coll_rdata;
  logic [7:0]  flash_q[$];
  logic [7:0]  jedec[3];

  assign miso  = lb ? mosi : miso_drv;
  assign miso1 = mosi1;

  spi_flash_ctrl #(.CLKDIV(D)) u_dut (
    .clk(clk), .resetq(resetq), .wr(wr), .rd(rd), .addr(addr), .wd(wd),
    .rdata(rdata), .sck(sck), .mosi(mosi), .miso(miso), .cs_n(cs_n)
  );

  spi_flash_ctrl #(.CLKDIV(1)) u_dut1 (
    .clk(clk), .resetq(resetq1), .wr(wr1), .rd(rd1), .addr(addr1), .wd(wd1),
    .rdata(rdata1), .sck(sck1), .mosi(mosi1), .miso(miso1), .cs_n(cs_n1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic status(output logic [15:0] s);
    addr = 1'b1;
    #1;
    s = rdata;
  endtask

  task automatic do_wr(input logic a, input logic [15:0] d);
    addr = a;
    wd   = d;
    wr   = 1'b1;
    cyc();
    wr   = 1'b0;
  endtask

  task automatic data_read(output logic [15:0] v);
    addr = 1'b0;
    rd   = 1'b1;
    #1;
    v    = rdata;
    cyc();
    rd   = 1'b0;
  endtask

  // One byte transfer; 'resp' is what the slave side shifts back when not in loopback.
  task automatic xfer(input logic [7:0] tx, input logic [7:0] resp, input int ovr_at,
                      input bit ovr_done, input int ctrl0_at, input bit rd_done);
    logic [15:0] s;
    logic        prev;
    n_busy   = 0;
    rises    = 0;
    highs    = 0;
    cap      = 8'h00;
    prev     = 1'b0;
    miso_drv = resp[7];
    do_wr(1'b0, {8'h00, tx});
    status(s);
    while (s[0] && n_busy < 100 * D) begin
      if (sck) highs++;
      if (sck && !prev) begin
        cap = {cap[6:0], mosi};
        rises++;
      end
      prev = sck;
      if (rises < 8) miso_drv = resp[3'(7 - rises)];
      if (n_busy == ovr_at || (ovr_done && n_busy == 16 * D - 1)) begin
        addr = 1'b0; wd = 16'h00FF; wr = 1'b1;
      end
      if (n_busy == ctrl0_at) begin
        addr = 1'b1; wd = 16'h0000; wr = 1'b1;
      end
      if (rd_done && n_busy == 16 * D - 1) begin
        addr = 1'b0; rd = 1'b1;
        #1;
        coll_rdata = rdata;
      end
      cyc();
      wr = 1'b0;
      rd = 1'b0;
      n_busy++;
      status(s);
    end
    chk("busy_cycles", n_busy, 16 * D);
    chk("sck_rises", rises, 8);
    chk("sck_high_cycles", highs, 8 * D);
    chk("mosi_bits", {24'h0, cap}, {24'h0, tx});
    chk("sck_idle", {31'h0, sck}, 32'h0);
    chk("mosi_hold_bit0", {31'h0, mosi}, {31'h0, tx[0]});
  endtask

  initial begin
    logic [15:0] s, v;
    logic [7:0]  tx, resp, exp_rx;
    logic        csb;
    int          r, n;
    logic        prev;

    jedec[0] = 8'hEF; jedec[1] = 8'h40; jedec[2] = 8'h16;
    resetq = 1'b0; wr = 1'b0; rd = 1'b0; addr = 1'b0; wd = 16'h0;
    lb = 1'b1; miso_drv = 1'b0;
    resetq1 = 1'b0; wr1 = 1'b0; rd1 = 1'b0; addr1 = 1'b1; wd1 = 16'h0;

    // Reset held while the bus wiggles.
    for (int i = 0; i < 3; i++) begin
      wr = 1'b1; addr = 1'($urandom); wd = 16'($urandom);
      cyc();
      wr = 1'b0;
      status(s);
      chk("rst_cs_n", {31'h0, cs_n}, 32'h1);
      chk("rst_sck", {31'h0, sck}, 32'h0);
      chk("rst_mosi", {31'h0, mosi}, 32'h0);
      chk("rst_status", {16'h0, s}, 32'h0);
    end
    resetq = 1'b1;
    cyc();

    // Loopback A5.
    do_wr(1'b1, 16'h0001);
    status(s);
    chk("cs_on_status", {16'h0, s}, 32'h0002);
    xfer(8'hA5, 8'h00, -1, 1'b0, -1, 1'b0);
    status(s);
    chk("lb_status_pre", {16'h0, s}, 32'h0006);
    data_read(v);
    chk("lb_data", {16'h0, v}, 32'h00A5);
    status(s);
    chk("lb_status_post", {16'h0, s}, 32'h0002);

    // Randomized bytes: loopback or random slave response, random CS state.
    for (int i = 0; i < 6; i++) begin
      tx  = 8'($urandom);
      resp = 8'($urandom);
      lb  = 1'($urandom);
      csb = 1'($urandom);
      exp_rx = lb ? tx : resp;
      do_wr(1'b1, {15'h0, csb});
      xfer(tx, resp, -1, 1'b0, -1, 1'b0);
      status(s);
      chk("rnd_status", {16'h0, s}, {28'h0, 2'b01, csb, 1'b0});
      data_read(v);
      chk("rnd_data", {16'h0, v}, {24'h0, exp_rx});
    end

    // JEDEC ID read against a behavioural flash.
    lb = 1'b0;
    flash_q.delete();
    do_wr(1'b1, 16'h0001);
    for (int k = 0; k < 4; k++) begin
      tx   = (k == 0) ? 8'h9F : 8'h00;
      resp = 8'hFF;
      if (k >= 1 && flash_q[0] == 8'h9F) resp = jedec[k - 1];
      xfer(tx, resp, -1, 1'b0, -1, 1'b0);
      flash_q.push_back(cap);
      data_read(v);
      chk("jedec_byte", {16'h0, v}, {24'h0, resp});
    end
    chk("jedec_cs_held", {31'h0, cs_n}, 32'h0);
    do_wr(1'b1, 16'h0000);
    chk("jedec_cs_off", {31'h0, cs_n}, 32'h1);

    // Overrun: writes mid-transfer and in the completion cycle.
    lb = 1'b1;
    do_wr(1'b1, 16'h0001);
    xfer(8'h3C, 8'h00, 5, 1'b1, -1, 1'b0);
    status(s);
    chk("ovr_status", {16'h0, s}, 32'h000E);
    data_read(v);
    chk("ovr_data", {16'h0, v}, 32'h003C);
    do_wr(1'b1, 16'h0003);
    status(s);
    chk("ovr_clear", {16'h0, s}, 32'h0002);
    chk("ovr_cs_kept", {31'h0, cs_n}, 32'h0);

    // CS deassert attempt while busy is ignored.
    xfer(8'hC3, 8'h00, -1, 1'b0, 7, 1'b0);
    chk("cs_busy_held", {31'h0, cs_n}, 32'h0);
    status(s);
    chk("cs_busy_status", {16'h0, s}, 32'h0006);

    // DATA read colliding with completion: set wins.
    xfer(8'h96, 8'h00, -1, 1'b0, -1, 1'b1);
    chk("coll_old_rx", {16'h0, coll_rdata}, 32'h00C3);
    status(s);
    chk("coll_valid_kept", {16'h0, s}, 32'h0006);
    data_read(v);
    chk("coll_new_rx", {16'h0, v}, 32'h0096);
    status(s);
    chk("coll_status_post", {16'h0, s}, 32'h0002);

    // CLKDIV=1: reset after three bits, then a clean transfer.
    resetq1 = 1'b1;
    cyc();
    addr1 = 1'b1; wd1 = 16'h0001; wr1 = 1'b1;
    cyc();
    addr1 = 1'b0; wd1 = 16'h00E7;
    cyc();
    wr1 = 1'b0;
    r = 0; n = 0; prev = 1'b0;
    while (r < 3 && n < 100) begin
      if (sck1 && !prev) r++;
      prev = sck1;
      if (r < 3) begin
        cyc();
        n++;
      end
    end
    chk("d1_rises_before_rst", r, 3);
    #1;
    resetq1 = 1'b0;
    addr1   = 1'b1;
    #1;
    chk("d1_rst_sck", {31'h0, sck1}, 32'h0);
    chk("d1_rst_mosi", {31'h0, mosi1}, 32'h0);
    chk("d1_rst_cs_n", {31'h0, cs_n1}, 32'h1);
    chk("d1_rst_status", {16'h0, rdata1}, 32'h0);
    #1;
    resetq1 = 1'b1;
    cyc();
    addr1 = 1'b1; wd1 = 16'h0001; wr1 = 1'b1;
    cyc();
    addr1 = 1'b0; wd1 = 16'h0081;
    cyc();
    wr1 = 1'b0; addr1 = 1'b1;
    #1;
    n = 0;
    while (rdata1[0] && n < 100) begin
      cyc();
      n++;
      #1;
    end
    chk("d1_busy_cycles", n, 16);
    addr1 = 1'b0;
    #1;
    chk("d1_data", {16'h0, rdata1}, 32'h0081);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/spi_flash_ctrl.md
Name: spi_flash_ctrl

Overview:
Byte-level SPI master that drives the board's serial configuration flash (SCK, MOSI, MISO, CS) for the j1 core. It replaces bit-banging of the flash pins through the misc.out port. It sits on the registered j1 IO bus (io_wr_/io_rd_/io_addr_/dout_) as one more decoded device. The CPU selects/deselects the flash, writes a byte, polls busy, then reads the received byte.

Parameters:
CLKDIV, 2, SCK half-period in clk cycles; legal range 1..255; 8-bit divider counter.

Ports:
clk  input  1  system clock
resetq  input  1  asynchronous active-low reset
wr  input  1  IO write strobe, already qualified by device decode; one-cycle pulse
rd  input  1  IO read strobe, already qualified by device decode; one-cycle pulse
addr  input  1  register select: 0 = DATA, 1 = CTRL/STATUS
wd  input  16  write data (dout_)
rdata  output  16  read data; combinational from addr and current state
sck  output  1  SPI clock, mode 0
mosi  output  1  SPI data out
miso  input  1  SPI data in; pre-synchronised externally
cs_n  output  1  flash chip select, active low

Behaviour:
- Reset is asynchronous: resetq, active-low; clock clk. Reset forces cs_n=1, sck=0, mosi=0, busy=0, rx=8'h00, rx_valid=0, overrun=0, divider=0, bit counter=0, FSM=IDLE. Reset during a transfer aborts it with no completion flag.
- FSM states:
  - IDLE: sck=0.
  - LOW: sck=0 for CLKDIV cycles.
  - HIGH: sck=1 for CLKDIV cycles.
  - Sequence is IDLE -> LOW -> HIGH -> LOW ... -> IDLE.
- DATA write (wr & addr==0) in IDLE:
  - Loads tx shift reg with wd[7:0]; mosi=wd[7] from the next cycle.
  - busy=1 from the next cycle; the FSM enters LOW.
- Bit timing (mode 0, MSB first):
  - At LOW->HIGH, sck rises and miso is shifted into the rx shift reg LSB.
  - At HIGH->LOW, sck falls and mosi advances to the next bit.
  - After the 8th HIGH phase the FSM returns to IDLE with sck=0, mosi holding bit0.
- Transfer latency: busy is high for exactly 16*CLKDIV cycles; exactly 8 sck rising edges.
- Completion (cycle the FSM enters IDLE): rx <= shifted byte, rx_valid <= 1, busy <= 0.
- DATA write while busy: data discarded, transfer unaffected, overrun <= 1. This includes the completion cycle, because busy is still 1 during it.
- DATA write with cs_n=1 is legal: clocks run with the flash deselected (dummy clocks).
- DATA read (rd & addr==0):
  - rdata = {8'h00, rx}; rx_valid cleared next cycle.
  - If completion coincides with the read, set wins and rx_valid stays 1.
- CTRL write (wr & addr==1):
  - wd[0]=1 asserts CS (cs_n=0); wd[0]=0 deasserts it.
  - wd[1]=1 clears overrun.
  - While busy, the wd[0] field is ignored (CS held) and the wd[1] field is still honoured.
- STATUS read (addr==1): rdata = {12'h000, overrun, rx_valid, ~cs_n, busy}; no side effects.
- wr and rd in the same cycle to the same register: both take effect.
- Outputs sck, mosi, cs_n are registered; no combinational path from any input to them.

Test Plan:
- Reset: hold resetq low, wiggle wr/wd -> cs_n=1, sck=0, mosi=0, STATUS=16'h0000.
- Loopback (miso tied to mosi), CLKDIV=2: write CTRL 1, write DATA 16'h00A5 -> busy high for exactly 32 cycles, 8 sck rising edges, each sck high for 2 cycles, mosi sequence 1,0,1,0,0,1,0,1. Then DATA read = 16'h00A5, STATUS = 16'h0006 before the read and 16'h0002 after.
- JEDEC ID with flash model: CS on, send 8'h9F, then three 8'h00 dummy bytes, model returns EF,40,16 -> rx reads 8'hEF, 8'h40, 8'h16 in order. CS off -> cs_n=1 only after the last busy falls.
- Overrun: DATA write 8'h3C, then DATA write 8'hFF at cycle 5 and again in the completion cycle -> received byte unaffected, STATUS bit3=1. CTRL write 16'h0003 -> bit3=0, CS stays on.
- CS write while busy: CTRL write 0 mid-transfer -> cs_n stays 0. Completion/read collision: DATA read in the completion cycle -> rx_valid remains 1 and new rx is visible next cycle.
- Reset mid-transfer after 3 bits, CLKDIV=1 -> all outputs return to reset values immediately. A new transfer of 8'h81 then completes normally in 16 cycles.
